// File: rtl/uart_pkg.sv
// Shared constants for the UART host sequencer: FSM encoding, strobe
// polarity and the round-robin pointer helper.
package uart_pkg;

  // Sequencer FSM encoding (kept as plain constants for legacy tools).
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WR   = 2'b01;
  localparam logic [1:0] ST_RD   = 2'b10;

  // CoreUART strobes (CSN/WEN/OEN) are active low.
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  // Start position of the next round-robin search once requester idx has won.
  function automatic logic [2:0] rr_next(input logic [2:0] idx, input int num_req);
    return (int'(idx) == num_req - 1) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin arbiter for the shared UART transmitter. While a packet lock
// is held only the locked owner may win; otherwise the search starts at ptr_i.
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [2:0]         ptr_i,
  input  logic               lock_i,
  input  logic [2:0]         lock_id_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [2:0]         idx_o,
  output logic               any_o
);

  logic [7:0] req8;
  logic [7:0] mask8;
  logic [3:0] pos;
  logic       found;

  // Masked circular search for the first eligible requester from ptr_i.
  always_comb begin
    req8                = '0;
    req8[NUM_REQ-1:0]   = req_i;
    mask8               = lock_i ? (req8 & (8'b1 << lock_id_i)) : req8;
    found               = 1'b0;
    idx_o               = '0;
    pos                 = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr_i} + 4'(k);
      if (pos >= 4'(NUM_REQ)) pos = pos - 4'(NUM_REQ);
      if (!found && mask8[pos[2:0]]) begin
        found = 1'b1;
        idx_o = pos[2:0];
      end
    end
    any_o = found;
    gnt_o = '0;
    for (int i = 0; i < NUM_REQ; i++) gnt_o[i] = found && (idx_o == 3'(i));
  end

endmodule

// File: rtl/uart_host_sequencer.sv
// Fabric-side sequencer for the CoreUART byte interface. Shares the
// transmitter among NUM_REQ requesters (round-robin with packet lock) and
// drains received bytes into a one-entry rx buffer.
//
// Handshakes: a requester byte moves when req_valid[i] is high and the
// one-hot req_ready[i] pulses (the WR cycle); an rx byte moves on a cycle
// where rx_valid and rx_ready are both high. Producers hold data stable
// while valid is high and ready is low.
module uart_host_sequencer #(
  parameter int NUM_REQ      = 4,
  parameter int TXRDY_SETTLE = 2
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [7:0]           rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_ovf,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 CSN,
  output logic                 WEN,
  output logic                 OEN,
  output logic [7:0]           DATA_IN,
  input  logic                 TXRDY,
  input  logic                 RXRDY,
  input  logic [7:0]           DATA_OUT,
  input  logic                 PARITY_ERR,
  input  logic                 FRAMING_ERR,
  input  logic                 OVERFLOW,
  output logic [1:0]           dbg_state
);
  import uart_pkg::*;

  logic [1:0]         state_q, state_d;
  logic               csn_q, csn_d, wen_q, wen_d, oen_q, oen_d;
  logic [7:0]         data_in_q, data_in_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic               rx_valid_q, rx_valid_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d, rx_ovf_q, rx_ovf_d;
  logic [2:0]         grant_id_q, grant_id_d;
  logic               lock_q, lock_d, last_q, last_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;
  logic [2:0]         settle_q, settle_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [2:0]         arb_idx;
  logic               arb_any;
  logic [7:0]         sel_byte;
  logic               sel_last;
  logic               go_rd, go_wr;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .lock_i    (lock_q),
    .lock_id_i (grant_id_q),
    .gnt_o     (arb_gnt),
    .idx_o     (arb_idx),
    .any_o     (arb_any)
  );

  // Byte and last flag of the current arbitration winner.
  always_comb begin
    sel_byte = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == 3'(i)) begin
        sel_byte = req_data[8*i +: 8];
        sel_last = req_last[i];
      end
    end
  end

  // Reads win over writes; a read needs room in the rx buffer this cycle.
  assign go_rd = RXRDY && (!rx_valid_q || rx_ready);
  assign go_wr = TXRDY && (settle_q == 3'd0) && arb_any;

  // Next-state, strobe, arbitration and rx-buffer logic.
  always_comb begin
    state_d     = state_q;
    csn_d       = STROBE_OFF;
    wen_d       = STROBE_OFF;
    oen_d       = STROBE_OFF;
    data_in_d   = data_in_q;
    req_ready_d = '0;
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;
    rx_perr_d   = rx_perr_q;
    rx_ferr_d   = rx_ferr_q;
    rx_ovf_d    = rx_ovf_q;
    grant_id_d  = grant_id_q;
    lock_d      = lock_q;
    last_d      = last_q;
    rr_ptr_d    = rr_ptr_q;
    settle_d    = (settle_q != 3'd0) ? settle_q - 3'd1 : 3'd0;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go_rd) begin
          state_d = ST_RD;
          csn_d   = STROBE_ON;
          oen_d   = STROBE_ON;
        end else if (go_wr) begin
          // Loading here keeps TXRDY masked for the WR cycle and the
          // following TXRDY_SETTLE-1 cycles, so writes start at most
          // once every TXRDY_SETTLE+1 cycles.
          state_d     = ST_WR;
          csn_d       = STROBE_ON;
          wen_d       = STROBE_ON;
          data_in_d   = sel_byte;
          last_d      = sel_last;
          req_ready_d = arb_gnt;
          grant_id_d  = arb_idx;
          rr_ptr_d    = rr_next(arb_idx, NUM_REQ);
          settle_d    = 3'(TXRDY_SETTLE);
        end
      end
      ST_WR: begin
        state_d = ST_IDLE;
        lock_d  = !last_q;
      end
      ST_RD: begin
        state_d    = ST_IDLE;
        rx_valid_d = 1'b1;
        rx_data_d  = DATA_OUT;
        rx_perr_d  = PARITY_ERR;
        rx_ferr_d  = FRAMING_ERR;
        rx_ovf_d   = OVERFLOW;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset drops any strobe in flight at once.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      csn_q       <= STROBE_OFF;
      wen_q       <= STROBE_OFF;
      oen_q       <= STROBE_OFF;
      data_in_q   <= '0;
      req_ready_q <= '0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_perr_q   <= 1'b0;
      rx_ferr_q   <= 1'b0;
      rx_ovf_q    <= 1'b0;
      grant_id_q  <= '0;
      lock_q      <= 1'b0;
      last_q      <= 1'b0;
      rr_ptr_q    <= '0;
      settle_q    <= '0;
    end else begin
      state_q     <= state_d;
      csn_q       <= csn_d;
      wen_q       <= wen_d;
      oen_q       <= oen_d;
      data_in_q   <= data_in_d;
      req_ready_q <= req_ready_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      rx_perr_q   <= rx_perr_d;
      rx_ferr_q   <= rx_ferr_d;
      rx_ovf_q    <= rx_ovf_d;
      grant_id_q  <= grant_id_d;
      lock_q      <= lock_d;
      last_q      <= last_d;
      rr_ptr_q    <= rr_ptr_d;
      settle_q    <= settle_d;
    end
  end

  assign CSN       = csn_q;
  assign WEN       = wen_q;
  assign OEN       = oen_q;
  assign DATA_IN   = data_in_q;
  assign req_ready = req_ready_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign rx_perr   = rx_perr_q;
  assign rx_ferr   = rx_ferr_q;
  assign rx_ovf    = rx_ovf_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q != ST_IDLE) || lock_q;
  assign dbg_state = state_q;

endmodule
